// File: rtl/bash_hash_params_pkg.sv
// Shared widths, sequencer state encoding and level helpers for the bash_hash
// core and its control front-end.
package bash_hash_params_pkg;

    localparam int SLEN           = 64;
    localparam int XLEN           = 32;
    localparam int BASH_ROUNDS    = 24;
    localparam int BASH_BLK_WORDS = 16;
    localparam int BASH_OUT_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        LOAD  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    // True for the three supported security levels.
    function automatic logic level_legal(input logic [XLEN-1:0] l);
        level_legal = (l == XLEN'(128)) || (l == XLEN'(192)) || (l == XLEN'(256));
    endfunction

    // Unsupported levels fall back to the strongest one.
    function automatic logic [XLEN-1:0] level_sanitize(input logic [XLEN-1:0] l);
        level_sanitize = level_legal(l) ? l : XLEN'(256);
    endfunction

    // Number of 64-bit digest words delivered for a level (l/32).
    function automatic logic [3:0] hash_words(input logic [XLEN-1:0] l);
        if (l == XLEN'(128)) begin
            hash_words = 4'd4;
        end else if (l == XLEN'(192)) begin
            hash_words = 4'd6;
        end else begin
            hash_words = 4'd8;
        end
    endfunction

endpackage

// File: rtl/bash_blk_buf.sv
// One-entry message block buffer (data + last flag). The sequencer frees the
// entry in the cycle it hands the block to the core, so the producer can
// refill it while that block is still being absorbed.
module bash_blk_buf
    import bash_hash_params_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           in_last_i,
    input  logic [BASH_BLK_WORDS*SLEN-1:0] in_data_i,
    input  logic                           free_i,
    output logic                           full_o,
    output logic                           last_o,
    output logic [BASH_BLK_WORDS*SLEN-1:0] data_o
);

    logic                           full_q, full_d;
    logic                           last_q, last_d;
    logic [BASH_BLK_WORDS*SLEN-1:0] data_q, data_d;
    logic                           accept;

    // Free takes effect before fill, so a same-cycle free+fill leaves it full.
    always_comb begin
        accept = in_valid_i & ~full_q;
        full_d = (full_q & ~free_i) | accept;
        last_d = accept ? in_last_i : last_q;
        data_d = accept ? in_data_i : data_q;
    end

    // Entry storage; reset discards any buffered block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

    assign in_ready_o = ~full_q;
    assign full_o     = full_q;
    assign last_o     = last_q;
    assign data_o     = data_q;

endmodule

// File: rtl/bash_hash_ctrl.sv
// Sequencer for the bash_hash sponge core: buffers incoming blocks, issues
// prep/start/work pulses, counts step cycles and returns the level-masked
// digest over a valid/ready stream.
module bash_hash_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int ROUNDS = BASH_ROUNDS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           msg_valid_i,
    output logic                           msg_ready_o,
    input  logic                           msg_last_i,
    input  logic [BASH_BLK_WORDS*SLEN-1:0] msg_data_i,
    input  logic [XLEN-1:0]                l_i,
    output logic                           prep_o,
    output logic                           start_o,
    output logic                           work_o,
    output logic                           first_o,
    output logic [XLEN-1:0]                l_o,
    output logic [BASH_BLK_WORDS*SLEN-1:0] x_o,
    input  logic [BASH_OUT_WORDS*SLEN-1:0] y_i,
    output logic                           hash_valid_o,
    input  logic                           hash_ready_i,
    output logic [BASH_OUT_WORDS*SLEN-1:0] hash_o,
    output logic                           hash_err_o,
    output logic                           busy_o
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    ctrl_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] l_q, l_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] l_pend_q, l_pend_d;     // level of a first block buffered early
    logic            err_pend_q, err_pend_d;
    logic            first_blk_q, first_blk_d;   // next accepted block opens a message
    logic            first_pend_q, first_pend_d; // next start_o is block 0
    logic            last_q, last_d;
    logic            prep_q, prep_d;
    logic            start_q, start_d;
    logic            work_q, work_d;
    logic            first_q, first_d;
    logic            hash_valid_q, hash_valid_d;
    logic            busy_q, busy_d;

    logic            buf_full;
    logic            buf_last;
    logic            accept;
    logic            full_next;
    logic [3:0]      n_words;

    bash_blk_buf u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (msg_valid_i),
        .in_ready_o (msg_ready_o),
        .in_last_i  (msg_last_i),
        .in_data_i  (msg_data_i),
        .free_i     (start_q),
        .full_o     (buf_full),
        .last_o     (buf_last),
        .data_o     (x_o)
    );

    // Next-state, level capture and registered control outputs.
    always_comb begin
        accept    = msg_valid_i & msg_ready_o;
        full_next = (buf_full & ~start_q) | accept;

        state_d      = state_q;
        cnt_d        = cnt_q;
        l_d          = l_q;
        err_d        = err_q;
        l_pend_d     = l_pend_q;
        err_pend_d   = err_pend_q;
        first_blk_d  = first_blk_q;
        first_pend_d = first_pend_q;
        last_d       = last_q;

        // The level travels with the first block of a message even if that
        // block arrives while the previous digest is still waiting in DONE.
        if (accept) begin
            first_blk_d = msg_last_i;
            if (first_blk_q) begin
                l_pend_d   = level_sanitize(l_i);
                err_pend_d = ~level_legal(l_i);
            end
        end

        case (state_q)
            IDLE: begin
                if (buf_full || accept) begin
                    state_d      = PREP;
                    first_pend_d = 1'b1;
                    if (accept && first_blk_q) begin
                        l_d   = level_sanitize(l_i);
                        err_d = ~level_legal(l_i);
                    end else begin
                        l_d   = l_pend_q;
                        err_d = err_pend_q;
                    end
                end
            end
            PREP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // start_q is only high when a block was present to hand over.
                if (start_q) begin
                    state_d      = ROUND;
                    cnt_d        = '0;
                    last_d       = buf_last;
                    first_pend_d = 1'b0;
                end
            end
            ROUND: begin
                if (cnt_q == CNT_W'(ROUNDS - 1)) begin
                    cnt_d   = '0;
                    state_d = last_q ? DONE : LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (hash_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        prep_d       = (state_d == PREP);
        start_d      = (state_d == LOAD) && full_next;
        work_d       = (state_d == ROUND);
        first_d      = start_d && first_pend_d;
        hash_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // Sequencer state, counter, level and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            l_q          <= '0;
            err_q        <= 1'b0;
            l_pend_q     <= '0;
            err_pend_q   <= 1'b0;
            first_blk_q  <= 1'b1;
            first_pend_q <= 1'b0;
            last_q       <= 1'b0;
            prep_q       <= 1'b0;
            start_q      <= 1'b0;
            work_q       <= 1'b0;
            first_q      <= 1'b0;
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            l_q          <= l_d;
            err_q        <= err_d;
            l_pend_q     <= l_pend_d;
            err_pend_q   <= err_pend_d;
            first_blk_q  <= first_blk_d;
            first_pend_q <= first_pend_d;
            last_q       <= last_d;
            prep_q       <= prep_d;
            start_q      <= start_d;
            work_q       <= work_d;
            first_q      <= first_d;
            hash_valid_q <= hash_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Digest words beyond l/32 are forced to zero.
    assign n_words = hash_words(l_q);

    genvar gi;
    generate
        for (gi = 0; gi < BASH_OUT_WORDS; gi++) begin : g_mask
            assign hash_o[gi*SLEN +: SLEN] = (4'(gi) < n_words) ? y_i[gi*SLEN +: SLEN] : '0;
        end
    endgenerate

    assign prep_o       = prep_q;
    assign start_o      = start_q;
    assign work_o       = work_q;
    assign first_o      = first_q;
    assign l_o          = l_q;
    assign hash_valid_o = hash_valid_q;
    assign hash_err_o   = err_q & hash_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Self-checking bench for bash_hash_ctrl. A small stand-in core folds each
// started block into a 512-bit state; the reference digest is computed from
// the generated blocks and level and queued for the output monitor.
module tb_bash_hash_ctrl;

    typedef struct packed {
        logic [511:0] h;
        logic         e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          msg_valid;
    logic          msg_ready_o;
    logic          msg_last;
    logic [1023:0] msg_data;
    logic [31:0]   l_in;
    logic          prep_o, start_o, work_o, first_o;
    logic [31:0]   l_o;
    logic [1023:0] x_o;
    logic [511:0]  y_in;
    logic          hash_valid_o;
    logic          hash_ready;
    logic [511:0]  hash_o;
    logic          hash_err_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 1'b0;

    exp_t         sb[$];
    logic [511:0] ref_acc;
    logic [511:0] core_acc;
    int           n_msg = 0;

    // monitor-recorded events
    int  n_prep = 0, n_start = 0, n_work = 0, n_first = 0, n_hv = 0;
    int  last_prep_cyc = 0, last_start_cyc = 0, last_work_cyc = 0;
    int  work_rise_cyc = 0, hv_rise_cyc = 0, last_acc_cyc = 0;
    bit  occ = 1'b0, work_prev = 1'b0, hv_prev = 1'b0;

    bash_hash_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .msg_valid_i  (msg_valid),
        .msg_ready_o  (msg_ready_o),
        .msg_last_i   (msg_last),
        .msg_data_i   (msg_data),
        .l_i          (l_in),
        .prep_o       (prep_o),
        .start_o      (start_o),
        .work_o       (work_o),
        .first_o      (first_o),
        .l_o          (l_o),
        .x_o          (x_o),
        .y_i          (y_in),
        .hash_valid_o (hash_valid_o),
        .hash_ready_i (hash_ready),
        .hash_o       (hash_o),
        .hash_err_o   (hash_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] fold(input logic [1023:0] x);
        logic [511:0] f;
        for (int k = 0; k < 8; k++) f[k*64 +: 64] = x[k*64 +: 64] ^ x[(k+8)*64 +: 64];
        return f;
    endfunction

    function automatic logic [511:0] rotl1(input logic [511:0] a);
        return {a[510:0], a[511]};
    endfunction

    function automatic logic [511:0] ref_digest(input logic [511:0] a, input logic [31:0] lvl);
        logic [511:0] r;
        int nw;
        nw = (lvl == 128) ? 4 : (lvl == 192) ? 6 : 8;
        r = a;
        for (int w = nw; w < 8; w++) r[w*64 +: 64] = '0;
        return r;
    endfunction

    // Stand-in core: absorbs each started block, restarting on block 0.
    always @(posedge clk) begin
        if (rst) core_acc <= '0;
        else if (start_o) core_acc <= rotl1(first_o ? 512'd0 : core_acc) ^ fold(x_o);
    end
    assign y_in = core_acc;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    task automatic send_block(input logic [1023:0] d, input bit last, input logic [31:0] lvl);
        int n;
        @(posedge clk); #1;
        msg_valid = 1'b1;
        msg_data  = d;
        msg_last  = last;
        l_in      = lvl;
        n = 0;
        forever begin
            @(negedge clk);
            if (msg_ready_o) break;
            n++;
            if (n > 2000) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
        l_in      = $urandom;
    endtask

    task automatic send_rand_block(input bit first, input bit last, input logic [31:0] lvl);
        logic [1023:0] b;
        for (int w = 0; w < 32; w++) b[w*32 +: 32] = $urandom;
        if (first) ref_acc = '0;
        ref_acc = rotl1(ref_acc) ^ fold(b);
        send_block(b, last, first ? lvl : $urandom);
    endtask

    task automatic push_exp(input logic [31:0] lvl);
        exp_t e;
        e.h = ref_digest(ref_acc, lvl);
        e.e = !(lvl == 128 || lvl == 192 || lvl == 256);
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while (sb.size() != 0 || busy_o) begin
            @(posedge clk); #1;
            if (rnd) hash_ready = ($urandom_range(0, 3) != 0);
            n++;
            if (n > 3000) begin
                timeout("wait_done");
                break;
            end
        end
        hash_ready = 1'b1;
    endtask

    // Output monitor: protocol rules, event log and digest scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ = 1'b0;
                work_prev = 1'b0;
                hv_prev = 1'b0;
            end else if (armed) begin
                if (prep_o || start_o || work_o)
                    chk("ctrl_onehot", 512'(int'(prep_o) + int'(start_o) + int'(work_o)), 512'd1);
                if (first_o) chk("first_with_start", 512'(start_o), 512'd1);
                chk("msg_ready_vs_buffer", 512'(msg_ready_o), 512'(!occ));
                if (msg_valid && msg_ready_o) last_acc_cyc = cyc;
                if (prep_o)  begin n_prep++;  last_prep_cyc = cyc;  end
                if (start_o) begin n_start++; last_start_cyc = cyc; end
                if (first_o) n_first++;
                if (work_o) begin
                    n_work++;
                    last_work_cyc = cyc;
                    if (!work_prev) work_rise_cyc = cyc;
                end
                if (hash_valid_o) begin
                    n_hv++;
                    if (!hv_prev) hv_rise_cyc = cyc;
                end
                if (hash_valid_o && hash_ready) begin
                    if (sb.size() == 0) begin
                        timeout("unexpected_digest");
                    end else begin
                        e = sb.pop_front();
                        chk("digest", hash_o, e.h);
                        chk("hash_err", 512'(hash_err_o), 512'(e.e));
                        n_msg++;
                        $display("msg %0d: digest taken at cycle %0d err=%0b", n_msg, cyc, hash_err_o);
                    end
                end
                occ = (occ && !start_o) || (msg_valid && msg_ready_o);
                work_prev = work_o;
                hv_prev = hash_valid_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, a, s_prep, s_start, s_work, s_first, s_hv, rel;
        int nb;
        logic [31:0] lvl;
        logic [511:0] exp4;
        logic [31:0] lvls [6];
        lvls = '{32'd128, 32'd192, 32'd256, 32'd160, 32'd0, 32'd512};

        rst = 1'b1; msg_valid = 1'b0; msg_last = 1'b0; msg_data = '0;
        l_in = '0; hash_ready = 1'b1;

        // ---- test 1: reset state, single block l=128, exact latency ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 512'({prep_o, start_o, work_o, first_o, hash_valid_o, busy_o, hash_err_o}), 512'd0);
        chk("rst_l_o", 512'(l_o), 512'd0);
        chk("rst_ready", 512'(msg_ready_o), 512'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 512'(msg_ready_o), 512'd1);
        chk("post_rst_ctrl", 512'({prep_o, start_o, work_o, hash_valid_o, busy_o}), 512'd0);

        s_work = n_work; s_hv = n_hv;
        send_rand_block(1'b1, 1'b1, 32'd128);
        t = last_acc_cyc;
        push_exp(32'd128);
        wait_done(1'b0);
        chk("t1_prep_cyc", 512'(last_prep_cyc), 512'(t + 1));
        chk("t1_start_cyc", 512'(last_start_cyc), 512'(t + 2));
        chk("t1_work_first", 512'(work_rise_cyc), 512'(t + 3));
        chk("t1_work_last", 512'(last_work_cyc), 512'(t + 26));
        chk("t1_work_count", 512'(n_work - s_work), 512'd24);
        chk("t1_hv_cyc", 512'(hv_rise_cyc), 512'(t + 27));
        chk("t1_hv_len", 512'(n_hv - s_hv), 512'd1);
        chk("t1_l_o", 512'(l_o), 512'd128);

        // ---- test 2: three blocks back-to-back, l=256 ----
        s_start = n_start; s_work = n_work; s_first = n_first;
        send_rand_block(1'b1, 1'b0, 32'd256);
        t = last_acc_cyc;
        send_rand_block(1'b0, 1'b0, 32'd0);
        send_rand_block(1'b0, 1'b1, 32'd0);
        push_exp(32'd256);
        wait_done(1'b0);
        chk("t2_first_count", 512'(n_first - s_first), 512'd1);
        chk("t2_start_count", 512'(n_start - s_start), 512'd3);
        chk("t2_work_count", 512'(n_work - s_work), 512'd72);
        chk("t2_hv_cyc", 512'(hv_rise_cyc), 512'(t + 1 + 3*25 + 1));

        // ---- test 3: second block 40 cycles late, stall in LOAD ----
        s_start = n_start; s_work = n_work;
        send_rand_block(1'b1, 1'b0, 32'd192);
        repeat (35) @(negedge clk);
        chk("t3_stall", 512'({work_o, start_o, busy_o, msg_ready_o}), 512'b0011);
        repeat (5) @(posedge clk);
        send_rand_block(1'b0, 1'b1, 32'd0);
        a = last_acc_cyc;
        push_exp(32'd192);
        wait_done(1'b0);
        chk("t3_resume_start", 512'(last_start_cyc), 512'(a + 1));
        chk("t3_start_count", 512'(n_start - s_start), 512'd2);
        chk("t3_work_count", 512'(n_work - s_work), 512'd48);

        // ---- test 4: digest held 10 cycles, next message waits ----
        @(posedge clk); #1;
        hash_ready = 1'b0;
        send_rand_block(1'b1, 1'b1, 32'd192);
        push_exp(32'd192);
        exp4 = ref_digest(ref_acc, 32'd192);
        t = 0;
        while (!hash_valid_o) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                timeout("t4_wait_valid");
                break;
            end
        end
        s_prep = n_prep;
        send_rand_block(1'b1, 1'b1, 32'd128);
        push_exp(32'd128);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 512'(hash_valid_o), 512'd1);
            chk("t4_hold_hash", hash_o, exp4);
        end
        chk("t4_no_prep", 512'(n_prep - s_prep), 512'd0);
        chk("t4_l_o_held", 512'(l_o), 512'd192);
        @(posedge clk); #1;
        rel = cyc;
        hash_ready = 1'b1;
        wait_done(1'b0);
        chk("t4_prep_after", 512'(n_prep - s_prep), 512'd1);
        chk("t4_prep_late", 512'(last_prep_cyc > rel), 512'd1);
        chk("t4_l_o_next", 512'(l_o), 512'd128);

        // ---- test 5: illegal level ----
        send_rand_block(1'b1, 1'b1, 32'd160);
        push_exp(32'd160);
        @(negedge clk);
        chk("t5_l_o", 512'(l_o), 512'd256);
        wait_done(1'b0);

        // ---- test 6: reset during round 10 of block 0 ----
        s_work = n_work;
        send_rand_block(1'b1, 1'b0, 32'd256);
        send_rand_block(1'b0, 1'b1, 32'd0);
        t = 0;
        while (n_work - s_work < 10) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                timeout("t6_wait_round");
                break;
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", 512'({prep_o, start_o, work_o, first_o, hash_valid_o, busy_o, hash_err_o}), 512'd0);
        chk("t6_rst_l_o", 512'(l_o), 512'd0);
        chk("t6_rst_ready", 512'(msg_ready_o), 512'd1);
        send_rand_block(1'b1, 1'b0, 32'd128);
        send_rand_block(1'b0, 1'b1, 32'd0);
        push_exp(32'd128);
        wait_done(1'b0);

        // ---- randomized messages with random gaps and back-pressure ----
        for (int m = 0; m < 10; m++) begin
            nb  = $urandom_range(1, 3);
            lvl = lvls[$urandom_range(0, 5)];
            for (int b = 0; b < nb; b++) begin
                send_rand_block(b == 0, b == nb - 1, lvl);
                if (b < nb - 1 && $urandom_range(0, 1) == 1)
                    repeat ($urandom_range(0, 30)) @(posedge clk);
            end
            push_exp(lvl);
            wait_done(1'b1);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
